// File: rtl/bec_load_pkg.sv
// Shared constants, slot codes and FSM state type for the BEC operand/key load path.
// No logic beyond the slot-code decode helper.
package bec_load_pkg;

  localparam int DEF_M        = 163;
  localparam int DEF_KEY_BITS = 163;

  localparam logic [2:0] SLOT_W1     = 3'd1;
  localparam logic [2:0] SLOT_Z1     = 3'd2;
  localparam logic [2:0] SLOT_W2     = 3'd3;
  localparam logic [2:0] SLOT_Z2     = 3'd4;
  localparam logic [2:0] SLOT_INV_W0 = 3'd5;
  localparam logic [2:0] SLOT_D      = 3'd6;

  localparam logic [5:0] MASK_FULL = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } bec_load_state_t;

  // Codes 0 and 7 map to an empty mask, which is how illegality is detected.
  function automatic logic [5:0] slot_onehot(input logic [2:0] code);
    logic [5:0] oh;
    oh = 6'h00;
    case (code)
      SLOT_W1:     oh = 6'h01;
      SLOT_Z1:     oh = 6'h02;
      SLOT_W2:     oh = 6'h04;
      SLOT_Z2:     oh = 6'h08;
      SLOT_INV_W0: oh = 6'h10;
      SLOT_D:      oh = 6'h20;
      default:     oh = 6'h00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bec_key_shifter.sv
// Scalar-key shift register: loads LSB-in during LOAD, replays MSB-first during RUN.
// One-cycle update per strobe; no backpressure, caller gates strobes by state.
module bec_key_shifter
  import bec_load_pkg::*;
#(
  parameter int KEY_BITS = DEF_KEY_BITS,
  parameter int CW       = $clog2(KEY_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load_shift,
  input  logic          ki,
  input  logic          replay_shift,
  output logic          key_bit,
  output logic          key_last,
  output logic [CW-1:0] key_cnt
);

  logic [KEY_BITS-1:0] key_sr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      key_sr  <= '0;
      key_cnt <= '0;
    end else if (load_shift) begin
      key_sr  <= {key_sr[KEY_BITS-2:0], ki};
      key_cnt <= key_cnt + CW'(1);
    end else if (replay_shift) begin
      key_sr  <= {key_sr[KEY_BITS-2:0], 1'b0};
      key_cnt <= key_cnt - CW'(1);
    end
  end

  assign key_bit  = key_sr[KEY_BITS-1];
  assign key_last = (key_cnt == CW'(1));

endmodule

// File: rtl/bec_load_unit.sv
// Receives operand words and serial key bits, holds them for the ladder, replays key MSB-first.
// Writes/acks land one cycle after the strobe; no backpressure, protocol violations raise sticky err.
module bec_load_unit
  import bec_load_pkg::*;
#(
  parameter int M        = DEF_M,
  parameter int KEY_BITS = DEF_KEY_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         load_data,
  input  logic [2:0]   load_status,
  input  logic [M-1:0] data_in,
  input  logic         ki,
  input  logic         next_key,
  input  logic         start,
  input  logic         key_req,
  output logic [M-1:0] w1,
  output logic [M-1:0] z1,
  output logic [M-1:0] w2,
  output logic [M-1:0] z2,
  output logic [M-1:0] inv_w0,
  output logic [M-1:0] d,
  output logic         load_ack,
  output logic         ready,
  output logic         key_bit,
  output logic         key_last,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(KEY_BITS + 1);

  bec_load_state_t state_q, state_nxt;
  logic [5:0]      mask_q, mask_nxt, slot_oh;
  logic [CW-1:0]   key_cnt;
  logic            key_last_raw;
  logic            in_load, wr_en, load_shift, replay_shift;
  logic            key_full, key_full_nxt, err_set;

  always_comb begin
    slot_oh      = slot_onehot(load_status);
    in_load      = (state_q == ST_LOAD);
    wr_en        = enable && in_load && load_data && (slot_oh != 6'h00);
    key_full     = (key_cnt == CW'(KEY_BITS));
    load_shift   = enable && in_load && next_key && !key_full;
    replay_shift = enable && (state_q == ST_RUN) && key_req;
    mask_nxt     = mask_q | (wr_en ? slot_oh : 6'h00);
    key_full_nxt = key_full || (load_shift && (key_cnt == CW'(KEY_BITS - 1)));
    err_set      = enable &&
                   ((in_load && ((load_data && (slot_oh == 6'h00)) || (next_key && key_full))) ||
                    ((state_q == ST_READY) && (load_data || next_key)));
  end

  // Next-state logic; a low enable overrides everything else.
  always_comb begin
    state_nxt = state_q;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_nxt = ST_LOAD;
        ST_LOAD:  if ((mask_nxt == MASK_FULL) && key_full_nxt) state_nxt = ST_READY;
        ST_READY: if (start) state_nxt = ST_RUN;
        ST_RUN:   if (replay_shift && key_last_raw) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      err      <= 1'b0;
      load_ack <= 1'b0;
      w1       <= '0;
      z1       <= '0;
      w2       <= '0;
      z2       <= '0;
      inv_w0   <= '0;
      d        <= '0;
    end else begin
      state_q  <= state_nxt;
      load_ack <= wr_en;
      if (!enable) begin
        mask_q <= '0;
        err    <= 1'b0;
      end else begin
        mask_q <= mask_nxt;
        if (err_set) err <= 1'b1;
      end
      // Operand contents deliberately survive an enable drop; only rst clears them.
      if (wr_en) begin
        case (load_status)
          SLOT_W1:     w1     <= data_in;
          SLOT_Z1:     z1     <= data_in;
          SLOT_W2:     w2     <= data_in;
          SLOT_Z2:     z2     <= data_in;
          SLOT_INV_W0: inv_w0 <= data_in;
          SLOT_D:      d      <= data_in;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    ready    = (state_q == ST_READY);
    busy     = (state_q == ST_RUN);
    key_last = (state_q == ST_RUN) && key_last_raw;
  end

  bec_key_shifter #(
    .KEY_BITS (KEY_BITS),
    .CW       (CW)
  ) u_key_shifter (
    .clk          (clk),
    .rst          (rst),
    .clr          (!enable),
    .load_shift   (load_shift),
    .ki           (ki),
    .replay_shift (replay_shift),
    .key_bit      (key_bit),
    .key_last     (key_last_raw),
    .key_cnt      (key_cnt)
  );

endmodule

// File: tb/tb_bec_load_unit.sv
// Scoreboard bench: stimulus pushes expected acks/key bits, a negedge monitor pops and compares.
module tb_bec_load_unit;

  localparam int M  = 163;
  localparam int KB = 163;

  typedef struct {
    int           slot;
    logic [M-1:0] data;
  } ack_t;

  logic         clk = 1'b0;
  logic         rst, enable, load_data, ki, next_key, start, key_req;
  logic [2:0]   load_status;
  logic [M-1:0] data_in;
  logic [M-1:0] w1, z1, w2, z2, inv_w0, d;
  logic         load_ack, ready, key_bit, key_last, busy, err;

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;
  ack_t       exp_ack[$];
  logic [1:0] exp_key[$];
  ack_t       mon_ack;
  logic [1:0] mon_key;

  bec_load_unit #(.M(M), .KEY_BITS(KB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load_data(load_data),
    .load_status(load_status), .data_in(data_in), .ki(ki), .next_key(next_key),
    .start(start), .key_req(key_req),
    .w1(w1), .z1(z1), .w2(w2), .z2(z2), .inv_w0(inv_w0), .d(d),
    .load_ack(load_ack), .ready(ready), .key_bit(key_bit), .key_last(key_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [M-1:0] slot_val(input int s);
    case (s)
      1: return w1;
      2: return z1;
      3: return w2;
      4: return z2;
      5: return inv_w0;
      6: return d;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit ld, input logic [2:0] st, input logic [M-1:0] dat,
                        input bit nk, input bit kb, input bit expect_ack);
    load_data = ld; load_status = st; data_in = dat; next_key = nk; ki = kb;
    if (expect_ack) exp_ack.push_back('{int'(st), dat});
    tick();
    load_data = 1'b0; next_key = 1'b0;
  endtask

  function automatic bit pat_bit(input int pat, input int i);
    return (pat == 0) ? (i % 2 == 0) : (i % 3 == 1);
  endfunction

  task automatic replay(input int n, input int pat);
    for (int i = 0; i < n; i++) exp_key.push_back({pat_bit(pat, i), (i == KB - 1)});
    for (int i = 0; i < n; i++) begin
      key_req = 1'b1;
      tick();
    end
    key_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_w1"}, w1, '0);         chk({tag, "_z1"}, z1, '0);
    chk({tag, "_w2"}, w2, '0);         chk({tag, "_z2"}, z2, '0);
    chk({tag, "_inv_w0"}, inv_w0, '0); chk({tag, "_d"}, d, '0);
    chk({tag, "_load_ack"}, M'(load_ack), '0);
    chk({tag, "_ready"}, M'(ready), '0);
    chk({tag, "_busy"}, M'(busy), '0);
    chk({tag, "_err"}, M'(err), '0);
    chk({tag, "_key_bit"}, M'(key_bit), '0);
    chk({tag, "_key_last"}, M'(key_last), '0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (load_ack) begin
        ack_seen++;
        if (exp_ack.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected got load_ack=1 expected 0");
        end else begin
          mon_ack = exp_ack.pop_front();
          chk($sformatf("ack_slot%0d", mon_ack.slot), slot_val(mon_ack.slot), mon_ack.data);
        end
      end
      if (busy && key_req) begin
        if (exp_key.size() == 0) begin
          checks++; errors++;
          $display("FAIL key_unexpected got a replay beat with no expectation");
        end else begin
          mon_key = exp_key.pop_front();
          chk("key_bit", M'(key_bit), M'(mon_key[1]));
          chk("key_last", M'(key_last), M'(mon_key[0]));
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; load_data = 1'b0; load_status = 3'd0; data_in = '0;
    ki = 1'b0; next_key = 1'b0; start = 1'b0; key_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Full load, last operand shares a cycle with the first key bit.
    enable = 1'b1;
    tick();
    for (int s = 1; s <= 5; s++) strobe(1, 3'(s), M'(s), 0, 0, 1);
    strobe(1, 3'd6, M'(6), 1, pat_bit(0, 0), 1);
    for (int i = 1; i < KB; i++) begin
      if (i == KB - 1) chk("ready_before_last_key", M'(ready), '0);
      strobe(0, 3'd0, '0, 1, pat_bit(0, i), 0);
    end
    chk("ready_after_last_key", M'(ready), M'(1));
    chk("ack_count", M'(ack_seen), M'(6));
    chk("w1_value", w1, M'(1));
    chk("d_value", d, M'(6));
    chk("err_after_load", M'(err), '0);

    // Strobes in READY: flagged, no write, no key shift.
    strobe(1, 3'd1, M'('hFF), 0, 0, 0);
    chk("ready_ld_err", M'(err), M'(1));
    chk("ready_ld_no_write", w1, M'(1));
    strobe(0, 3'd0, '0, 1, 0, 0);
    chk("ready_held", M'(ready), M'(1));

    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", M'(busy), M'(1));
    replay(KB, 0);
    chk("busy_after_done", M'(busy), '0);
    chk("ready_in_done", M'(ready), '0);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ignored_in_done", M'(busy), '0);

    enable = 1'b0; tick();
    chk("drop_err_clear", M'(err), '0);
    chk("drop_w1_kept", w1, M'(1));
    enable = 1'b1; tick();

    // Illegal slot code.
    strobe(1, 3'd7, M'('h77), 0, 0, 0);
    chk("illegal_err", M'(err), M'(1));
    chk("illegal_w1_kept", w1, M'(1));
    chk("illegal_d_kept", d, M'(6));
    enable = 1'b0; tick();
    chk("illegal_err_clear", M'(err), '0);
    enable = 1'b1; tick();

    // Key first, then slot 1 written twice; ready only once every slot is back.
    for (int i = 0; i < KB; i++) strobe(0, 3'd0, '0, 1, 1, 0);
    chk("mask_cleared_ready", M'(ready), '0);
    strobe(1, 3'd1, M'('hA), 0, 0, 1);
    strobe(1, 3'd1, M'('hB), 0, 0, 1);
    chk("rewrite_w1", w1, M'('hB));
    chk("rewrite_ready", M'(ready), '0);
    for (int s = 2; s <= 5; s++) strobe(1, 3'(s), M'(s + 'h10), 0, 0, 1);
    chk("partial_ready", M'(ready), '0);
    strobe(1, 3'd6, M'('h16), 0, 0, 1);
    chk("rewrite_full_ready", M'(ready), M'(1));

    // Key overflow in LOAD.
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    for (int i = 0; i < KB; i++) strobe(0, 3'd0, '0, 1, pat_bit(1, i), 0);
    chk("key_163_no_err", M'(err), '0);
    strobe(0, 3'd0, '0, 1, 1'b1, 0);
    chk("key_164_err", M'(err), M'(1));
    for (int s = 1; s <= 6; s++) begin
      if (s == 6) chk("ovf_ready_before_d", M'(ready), '0);
      strobe(1, 3'(s), M'(s + 'h20), 0, 0, 1);
    end
    chk("ovf_ready_exact_count", M'(ready), M'(1));

    // Reset in the middle of replay.
    start = 1'b1; tick(); start = 1'b0;
    replay(49, 1);
    chk("bit50_visible", M'(key_bit), M'(1));
    chk("busy_mid_run", M'(busy), M'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    check_all_zero("mid_run_rst");

    // Enable drop wins over a simultaneous load.
    tick();
    enable = 1'b0;
    strobe(1, 3'd1, M'(5), 1, 1, 0);
    chk("enable_prio_no_write", w1, '0);
    chk("enable_prio_no_ack", M'(load_ack), '0);
    tick();

    chk("ack_queue_drained", M'(exp_ack.size()), '0);
    chk("key_queue_drained", M'(exp_key.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bec_load_unit.md
# bec_load_unit

Operand/key receive end of the controller→BEC load protocol. Accepts 163-bit operand words tagged by `load_status` with a `load_data` strobe, and serial scalar-key bits via `ki`/`next_key`. Holds them in the BEC core's operand registers, then replays the key MSB-first to the ladder datapath on request. Sits inside the BEC core between the config bus and the GF(2^163) datapath.

## Interface
- `M`, 163: field/operand width in bits.
- `KEY_BITS`, 163: scalar key length.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  master enable from controller; low aborts and clears load progress.
- `load_data`  in  1  one-cycle strobe: `data_in` valid for slot `load_status`.
- `load_status`  in  3  slot code: 1=W1, 2=Z1, 3=W2, 4=Z2, 5=INV_W0, 6=D; 0 and 7 are illegal.
- `data_in`  in  M  operand word.
- `ki`  in  1  key bit, valid with `next_key`.
- `next_key`  in  1  one-cycle strobe: shift `ki` into key register.
- `start`  in  1  datapath request to begin key replay.
- `key_req`  in  1  datapath consumed current `key_bit`; advance.
- `w1, z1, w2, z2, inv_w0, d`  out  M each  operand registers.
- `load_ack`  out  1  one-cycle pulse per accepted operand write.
- `ready`  out  1  all six slots and all key bits loaded.
- `key_bit`  out  1  current key bit (MSB of key register).
- `key_last`  out  1  `key_bit` is the final bit.
- `busy`  out  1  replay in progress.
- `err`  out  1  sticky protocol error.

## Operation
- States: IDLE, LOAD, READY, RUN, DONE.
- IDLE: `enable`=1 → LOAD. Nothing is sampled in IDLE.
- LOAD:
  - `load_data` with legal code writes the register and sets that mask bit.
  - A rewrite of the same slot overwrites the register; the mask is unchanged.
  - `load_data` with code 0/7 writes nothing and sets `err`.
  - `next_key`: key_sr ← {key_sr[KEY_BITS-2:0], ki}, key_cnt++.
  - `next_key` at key_cnt==KEY_BITS is ignored and sets `err`.
  - mask==6'h3F and key_cnt==KEY_BITS → READY.
- READY: `ready`=1. `start` → RUN. `load_data`/`next_key` in READY set `err` and change no state.
- RUN: `busy`=1.
  - `key_bit`=key_sr[KEY_BITS-1].
  - `key_req` shifts key_sr left (zero fill) and decrements key_cnt.
  - `key_last`=(key_cnt==1).
  - `key_req` at key_cnt==1 → DONE.
- DONE: holds until `enable` falls.
- `enable`=0 in any state → IDLE next cycle; clears mask, key_cnt, key_sr and `err`. Operand registers keep their contents. `enable`=0 takes priority over every simultaneous strobe.
- `load_data` and `next_key` in the same cycle: both are processed.
- `start` outside READY and `key_req` outside RUN: ignored, no error.

## Timing
- All outputs are registered.
- Reset values: all operand registers 0, key_sr 0, key_cnt 0, state IDLE, and every flag output 0.
- Operand write: strobe in cycle n → register updated and `load_ack`=1 in cycle n+1 (exactly one cycle).
- Last required load or key bit in cycle n → `ready`=1 from cycle n+1.
- `start` in cycle n → `busy`=1 and first valid `key_bit` in cycle n+1.
- `key_req` in cycle n → next `key_bit` in cycle n+1. `key_req` may be asserted every cycle.
- `err` is set one cycle after the offending strobe.
- `rst` mid-load or mid-replay: full reset next cycle, including the operand registers.

## Structure
- Package `bec_load_pkg`:
  - `M`, `KEY_BITS` defaults;
  - slot code localparams `SLOT_W1`…`SLOT_D`;
  - state enum `bec_load_state_t`;
  - `MASK_FULL`=6'h3F.
- Sub-module `bec_key_shifter` holds key_sr and key_cnt, with load-shift, replay-shift, clear, `key_bit` and `key_last`.
- FSM, slot decode, operand registers and mask stay in `bec_load_unit`.

## Test plan
1. Load codes 1..6 with data 163'h1..163'h6, then 163 key bits of alternating 1/0 → `load_ack` 6 pulses, `ready`=1 the cycle after the last bit, `w1`=1, `d`=6.
2. From READY, pulse `start`, then hold `key_req` high for 163 cycles → `key_bit` sequence 1,0,1,…; `key_last` only on bit 163; DONE; `busy`=0.
3. `load_status`=7 with `load_data` → no register changes, `err`=1. Drop `enable` → `err`=0, state IDLE, mask cleared, `w1` retained.
4. Write slot 1 twice (163'hA then 163'hB) → `w1`=163'hB, `ready` stays 0 until slots 2..6 and the key are loaded.
5. Assert `next_key` 164 times → 164th strobe ignored, `err`=1, key_cnt=163.
6. `rst` mid-RUN at bit 50 → next cycle all outputs 0, IDLE; `enable` low with `load_data` in the same cycle → no write, no `load_ack`.
